// File: rtl/hazard_control_unit_if.sv
// Decode/execute hazard bus between the pipeline and hazard_control_unit.
// Optional macro STALL_COUNTER_EN adds the stall_cnt observation signal.
interface hazard_control_unit_if;
  localparam int unsigned REG_W   = 3;
  localparam int unsigned STATE_W = 2;
  localparam int unsigned CNT_W   = 16;

  logic [REG_W-1:0]   Rsrc1;
  logic [REG_W-1:0]   Rsrc2;
  logic               use_src1;
  logic               use_src2;
  logic [REG_W-1:0]   ex_Rdst;
  logic               ex_WB;
  logic               ex_mem_read;
  logic               branch_taken;
  logic               mem_busy;
  logic               pc_en;
  logic               ifid_en;
  logic               idex_en;
  logic               exmem_en;
  logic               idex_bubble;
  logic               ifid_flush;
  logic               idex_flush;
  logic [STATE_W-1:0] state;
`ifdef STALL_COUNTER_EN
  logic [CNT_W-1:0]   stall_cnt;
`endif

  modport master (
    output Rsrc1, Rsrc2, use_src1, use_src2, ex_Rdst, ex_WB, ex_mem_read,
    output branch_taken, mem_busy,
    input  pc_en, ifid_en, idex_en, exmem_en, idex_bubble, ifid_flush, idex_flush,
    input  state
`ifdef STALL_COUNTER_EN
    , input stall_cnt
`endif
  );

  modport slave (
    input  Rsrc1, Rsrc2, use_src1, use_src2, ex_Rdst, ex_WB, ex_mem_read,
    input  branch_taken, mem_busy,
    output pc_en, ifid_en, idex_en, exmem_en, idex_bubble, ifid_flush, idex_flush,
    output state
`ifdef STALL_COUNTER_EN
    , output stall_cnt
`endif
  );
endinterface

// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller: load-use stall, memory freeze and branch flush.
// Define STALL_COUNTER_EN to add a saturating count of pc-stalled cycles.
module hazard_control_unit (
  input  logic                 clk,
  input  logic                 rst,
  hazard_control_unit_if.slave bus
);
  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    LU_STALL = 2'b01,
    MEM_WAIT = 2'b10,
    FLUSH    = 2'b11
  } state_e;

  state_e state_q, state_d;

  logic src1_hit_c, src2_hit_c, lu_hazard_c;
  logic pc_en_c, ifid_en_c, idex_en_c, exmem_en_c;
  logic idex_bubble_c, ifid_flush_c, idex_flush_c;

  assign src1_hit_c  = bus.use_src1 && (bus.Rsrc1 == bus.ex_Rdst);
  assign src2_hit_c  = bus.use_src2 && (bus.Rsrc2 == bus.ex_Rdst);
  assign lu_hazard_c = bus.ex_mem_read && bus.ex_WB && (src1_hit_c || src2_hit_c);

  // Next state and combinational pipeline controls
  always_comb begin
    state_d       = state_q;
    pc_en_c       = 1'b1;
    ifid_en_c     = 1'b1;
    idex_en_c     = 1'b1;
    exmem_en_c    = 1'b1;
    idex_bubble_c = 1'b0;
    ifid_flush_c  = 1'b0;
    idex_flush_c  = 1'b0;

    unique case (state_q)
      RUN, LU_STALL, MEM_WAIT: begin
        if (state_q == MEM_WAIT && bus.mem_busy) begin
          pc_en_c    = 1'b0;
          ifid_en_c  = 1'b0;
          idex_en_c  = 1'b0;
          exmem_en_c = 1'b0;
        end else if (bus.branch_taken) begin
          ifid_flush_c = 1'b1;
          idex_flush_c = 1'b1;
          state_d      = FLUSH;
        end else if (bus.mem_busy) begin
          pc_en_c    = 1'b0;
          ifid_en_c  = 1'b0;
          idex_en_c  = 1'b0;
          exmem_en_c = 1'b0;
          state_d    = MEM_WAIT;
        end else if (lu_hazard_c && state_q != LU_STALL) begin
          pc_en_c       = 1'b0;
          ifid_en_c     = 1'b0;
          idex_bubble_c = 1'b1;
          state_d       = LU_STALL;
        end else begin
          state_d = RUN;
        end
      end
      FLUSH: begin
        if (bus.mem_busy) begin
          pc_en_c    = 1'b0;
          ifid_en_c  = 1'b0;
          idex_en_c  = 1'b0;
          exmem_en_c = 1'b0;
        end else begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase

    // Reset holds the pipeline with a NOP in ID/EX
    if (rst) begin
      state_d       = RUN;
      pc_en_c       = 1'b0;
      ifid_en_c     = 1'b0;
      idex_en_c     = 1'b0;
      exmem_en_c    = 1'b0;
      idex_bubble_c = 1'b1;
      ifid_flush_c  = 1'b0;
      idex_flush_c  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  assign bus.pc_en       = pc_en_c;
  assign bus.ifid_en     = ifid_en_c;
  assign bus.idex_en     = idex_en_c;
  assign bus.exmem_en    = exmem_en_c;
  assign bus.idex_bubble = idex_bubble_c;
  assign bus.ifid_flush  = ifid_flush_c;
  assign bus.idex_flush  = idex_flush_c;
  assign bus.state       = 2'(state_q);

`ifdef STALL_COUNTER_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of cycles where the PC is held outside reset
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!pc_en_c && stall_cnt_q != {CNT_W{1'b1}}) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign bus.stall_cnt = stall_cnt_q;
`endif
endmodule
